// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern detector and its run-control wrapper.
package seq_det_pkg;

  localparam int SD_MAX_LEN = 16;
  localparam int SD_CNT_W   = 8;
  localparam int SD_WIN_W   = 16;
  localparam int SD_LEN_W   = $clog2(SD_MAX_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SD_MAX_LEN-1:0] pattern;
    logic [SD_LEN_W-1:0]   len;
    logic                  overlap;
    logic [SD_CNT_W-1:0]   target;
    logic [SD_WIN_W-1:0]   window;
  } cfg_t;

  function automatic logic len_legal(input logic [SD_LEN_W-1:0] len);
    return (len != '0) && (len <= SD_LEN_W'(SD_MAX_LEN));
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// Serial shift register with fill tracking; flags whether the bit on i_x completes the pattern.
module seq_shift_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = SD_MAX_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_shift_en,
  input  logic                         i_clear,
  input  logic                         i_x,
  input  logic [MAX_LEN-1:0]           i_pattern,
  input  logic [$clog2(MAX_LEN):0]     i_len,
  output logic                         o_match_next
);

  localparam int LEN_W  = $clog2(MAX_LEN) + 1;
  localparam int FILL_W = LEN_W + 1;

  logic [MAX_LEN-1:0] r_shift;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_shift_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_filled;

  assign w_shift_next = {r_shift[MAX_LEN-2:0], i_x};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(i_len));
    end
  end

  // The incoming bit counts toward the fill, hence the +1 before comparing to len.
  assign w_filled     = ({1'b0, r_fill} + FILL_W'(1)) >= {1'b0, i_len};
  assign o_match_next = w_filled && (((w_shift_next ^ i_pattern) & w_mask) == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift <= '0;
      r_fill  <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_fill  <= '0;
    end else if (i_shift_en) begin
      r_shift <= w_shift_next;
      if (r_fill != LEN_W'(MAX_LEN)) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-control wrapper: config handshake, arm/abort, hit and window counting, status pulses.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = SD_MAX_LEN,
  parameter  int CNT_W   = SD_CNT_W,
  parameter  int WIN_W   = SD_WIN_W,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  // cfg_valid_i/cfg_ready_o: a config transfers on any edge where both are high;
  // cfg_ready_o depends only on state, never on cfg_valid_i.
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic [CNT_W-1:0]   cfg_target_i,
  input  logic [WIN_W-1:0]   cfg_window_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               x_valid_i,
  input  logic               x_i,
  output logic               det_o,
  output logic [CNT_W-1:0]   hit_cnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic               cfg_err_o
);

  state_t           r_state;
  state_t           w_state_next;
  cfg_t             r_cfg;
  cfg_t             w_cfg_in;
  logic             r_cfg_ok;
  logic             r_cfg_err;
  logic             r_det;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] w_hit_inc;
  logic [WIN_W-1:0] r_bit_cnt;
  logic [WIN_W-1:0] w_bit_inc;
  logic             w_idle;
  logic             w_armed;
  logic             w_cfg_take;
  logic             w_cfg_legal;
  logic             w_start_go;
  logic             w_start_bad;
  logic             w_accept;
  logic             w_match_next;
  logic             w_hit;
  logic             w_target_end;
  logic             w_window_end;
  logic             w_clear;

  assign w_idle      = (r_state == IDLE);
  assign w_armed     = (r_state == ARMED);
  assign w_cfg_take  = w_idle & cfg_valid_i;
  assign w_cfg_legal = len_legal(cfg_len_i);
  // A config in the same cycle as start wins; the start is dropped entirely.
  assign w_start_go  = w_idle & ~cfg_valid_i & start_i & r_cfg_ok;
  assign w_start_bad = w_idle & ~cfg_valid_i & start_i & ~r_cfg_ok;
  assign w_accept    = w_armed & x_valid_i & ~abort_i;
  assign w_hit       = w_accept & w_match_next;
  assign w_hit_inc   = (&r_hit_cnt) ? r_hit_cnt : r_hit_cnt + CNT_W'(1);
  assign w_bit_inc   = r_bit_cnt + WIN_W'(1);

  assign w_target_end = w_hit & (r_cfg.target != '0) & (w_hit_inc == r_cfg.target);
  assign w_window_end = w_accept & (r_cfg.window != '0) & (w_bit_inc == r_cfg.window);
  assign w_clear      = w_start_go | (w_hit & ~r_cfg.overlap);

  always_comb begin
    w_cfg_in         = '0;
    w_cfg_in.pattern = cfg_pattern_i;
    w_cfg_in.len     = cfg_len_i;
    w_cfg_in.overlap = cfg_overlap_i;
    w_cfg_in.target  = cfg_target_i;
    w_cfg_in.window  = cfg_window_i;
  end

  seq_shift_match #(
    .MAX_LEN(MAX_LEN)
  ) u_match (
    .clk         (clk),
    .reset       (reset),
    .i_shift_en  (w_accept),
    .i_clear     (w_clear),
    .i_x         (x_i),
    .i_pattern   (r_cfg.pattern),
    .i_len       (r_cfg.len),
    .o_match_next(w_match_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start_go) w_state_next = ARMED;
      ARMED: begin
        if (abort_i) begin
          w_state_next = IDLE;
        end else if (w_target_end | w_window_end) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o = (r_state == IDLE);
    busy_o      = (r_state == ARMED);
    done_o      = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cfg     <= '0;
      r_cfg_ok  <= 1'b0;
      r_cfg_err <= 1'b0;
      r_det     <= 1'b0;
      r_timeout <= 1'b0;
      r_hit_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_det <= w_hit;
      if (w_cfg_take) begin
        if (w_cfg_legal) begin
          r_cfg     <= w_cfg_in;
          r_cfg_ok  <= 1'b1;
          r_cfg_err <= 1'b0;
        end else begin
          r_cfg_ok  <= 1'b0;
          r_cfg_err <= 1'b1;
        end
      end else if (w_start_bad) begin
        r_cfg_err <= 1'b1;
      end
      if (w_start_go) begin
        r_hit_cnt <= '0;
        r_bit_cnt <= '0;
        r_timeout <= 1'b0;
      end else if (w_accept) begin
        r_bit_cnt <= w_bit_inc;
        if (w_hit) r_hit_cnt <= w_hit_inc;
        // Reaching the target on the window's last bit is a normal finish.
        if (w_window_end & ~w_target_end) r_timeout <= 1'b1;
      end
    end
  end

  assign det_o     = r_det;
  assign hit_cnt_o = r_hit_cnt;
  assign timeout_o = r_timeout;
  assign cfg_err_o = r_cfg_err;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus random traffic against a bit-history model.
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 8;
  localparam int WIN_W   = 16;
  localparam int LEN_W   = 5;
  localparam int EXP_W   = 6 + CNT_W;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cfg_valid_i = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern_i = '0;
  logic [LEN_W-1:0]   cfg_len_i = '0;
  logic               cfg_overlap_i = 1'b0;
  logic [CNT_W-1:0]   cfg_target_i = '0;
  logic [WIN_W-1:0]   cfg_window_i = '0;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic               x_valid_i = 1'b0;
  logic               x_i = 1'b0;
  logic               cfg_ready_o;
  logic               det_o;
  logic [CNT_W-1:0]   hit_cnt_o;
  logic               busy_o;
  logic               done_o;
  logic               timeout_o;
  logic               cfg_err_o;

  always #5 clk = ~clk;

  seq_det_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_pattern_i(cfg_pattern_i),
    .cfg_len_i    (cfg_len_i),
    .cfg_overlap_i(cfg_overlap_i),
    .cfg_target_i (cfg_target_i),
    .cfg_window_i (cfg_window_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .x_valid_i    (x_valid_i),
    .x_i          (x_i),
    .det_o        (det_o),
    .hit_cnt_o    (hit_cnt_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .cfg_err_o    (cfg_err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int det_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the accepted bits since the last start (or non-overlapping hit) and
  // matches by comparing the newest len bits against the pattern.
  bit               m_armed = 0, m_done = 0, m_det = 0, m_cfg_ok = 0, m_err = 0, m_timeout = 0;
  logic [CNT_W-1:0] m_hits = '0;
  logic [WIN_W-1:0] m_bits = '0;
  logic [MAX_LEN-1:0] m_pat = '0;
  int               m_len = 0;
  bit               m_ov = 0;
  logic [CNT_W-1:0] m_tgt = '0;
  logic [WIN_W-1:0] m_win = '0;
  bit               hist[$];
  logic [EXP_W-1:0] exp_q[$];

  task automatic model_step();
    bit matched;
    m_det = 0;
    if (!reset) begin
      m_armed = 0; m_done = 0; m_cfg_ok = 0; m_err = 0; m_timeout = 0;
      m_hits = '0; m_bits = '0; hist.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_armed) begin
      if (cfg_valid_i) begin
        if (cfg_len_i == 0 || int'(cfg_len_i) > MAX_LEN) begin
          m_cfg_ok = 0; m_err = 1;
        end else begin
          m_pat = cfg_pattern_i; m_len = int'(cfg_len_i); m_ov = cfg_overlap_i;
          m_tgt = cfg_target_i; m_win = cfg_window_i; m_cfg_ok = 1; m_err = 0;
        end
      end else if (start_i) begin
        if (m_cfg_ok) begin
          m_armed = 1; hist.delete(); m_bits = '0; m_hits = '0; m_timeout = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (abort_i) begin
      m_armed = 0;
    end else if (x_valid_i) begin
      hist.push_back(x_i);
      if (hist.size() > MAX_LEN) void'(hist.pop_front());
      m_bits = m_bits + WIN_W'(1);
      matched = (hist.size() >= m_len);
      for (int k = 0; k < m_len && matched; k++) begin
        if (hist[hist.size() - 1 - k] != m_pat[k]) matched = 0;
      end
      if (matched) begin
        m_det = 1;
        if (m_hits != '1) m_hits = m_hits + CNT_W'(1);
        if (!m_ov) hist.delete();
      end
      if (matched && m_tgt != 0 && m_hits == m_tgt) begin
        m_armed = 0; m_done = 1; m_timeout = 0;
      end else if (m_win != 0 && m_bits == m_win) begin
        m_armed = 0; m_done = 1; m_timeout = 1;
      end
    end
    exp_q.push_back({!m_armed && !m_done, m_armed, m_det, m_done, m_timeout, m_err, m_hits});
  endtask

  always @(posedge clk) begin
    det_seen += int'(det_o);
    model_step();
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e_vec;
    if (exp_q.size() != 0) begin
      e_vec = exp_q.pop_front();
      check("m_cfg_ready", cfg_ready_o, e_vec[EXP_W-1]);
      check("m_busy",      busy_o,      e_vec[EXP_W-2]);
      check("m_det",       det_o,       e_vec[EXP_W-3]);
      check("m_done",      done_o,      e_vec[EXP_W-4]);
      check("m_timeout",   timeout_o,   e_vec[EXP_W-5]);
      check("m_cfg_err",   cfg_err_o,   e_vec[EXP_W-6]);
      check("m_hit_cnt",   hit_cnt_o,   e_vec[CNT_W-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    cfg_valid_i = 0; start_i = 0; abort_i = 0; x_valid_i = 0; x_i = 0;
  endtask

  task automatic do_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                        input bit ov, input logic [CNT_W-1:0] t, input logic [WIN_W-1:0] w);
    step();
    for (int i = 0; i < 4 && !cfg_ready_o; i++) step();
    check("cfg_ready_wait", cfg_ready_o, 1);
    cfg_pattern_i = p; cfg_len_i = l; cfg_overlap_i = ov;
    cfg_target_i = t; cfg_window_i = w; cfg_valid_i = 1;
  endtask

  task automatic do_start();
    step();
    start_i = 1;
  endtask

  task automatic bit_in(input bit b);
    step();
    x_valid_i = 1; x_i = b;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [MAX_LEN-1:0] pat;
    int r;

    reset = 0;
    step(); step();
    check("rst_ready", cfg_ready_o, 1);
    check("rst_busy",  busy_o, 0);
    check("rst_hit",   hit_cnt_o, 0);
    check("rst_err",   cfg_err_o, 0);
    reset = 1;

    // Basic 12-bit run ending on target 1.
    pat = 16'h0EDB;
    do_cfg(pat, 5'd12, 0, 8'd1, 16'd0);
    do_start();
    for (int i = 11; i >= 0; i--) bit_in(pat[i]);
    step();
    check("basic_det",  det_o, 1);
    check("basic_done", done_o, 1);
    check("basic_hit",  hit_cnt_o, 1);
    step();
    check("basic_idle", cfg_ready_o, 1);

    // Overlapping 101 on 10101.
    do_cfg(16'h5, 5'd3, 1, 8'd0, 16'd0);
    do_start();
    det_seen = 0;
    pat = 16'h15;
    for (int i = 4; i >= 0; i--) bit_in(pat[i]);
    step(); step();
    check("ovl_dets", det_seen, 2);
    check("ovl_hit",  hit_cnt_o, 2);
    check("ovl_busy", busy_o, 1);
    abort_i = 1;
    step();
    check("ovl_abort_idle", busy_o, 0);
    check("ovl_abort_hold", hit_cnt_o, 2);

    // Non-overlapping 101 on 10101.
    do_cfg(16'h5, 5'd3, 0, 8'd0, 16'd0);
    do_start();
    det_seen = 0;
    for (int i = 4; i >= 0; i--) bit_in(pat[i]);
    step(); step();
    check("novl_dets", det_seen, 1);
    check("novl_hit",  hit_cnt_o, 1);
    check("novl_busy", busy_o, 1);
    abort_i = 1;

    // Window expiry, then target/window tie.
    do_cfg(16'hF, 5'd4, 0, 8'd0, 16'd8);
    do_start();
    for (int i = 0; i < 8; i++) bit_in(0);
    step();
    check("win_done",    done_o, 1);
    check("win_timeout", timeout_o, 1);
    check("win_hit",     hit_cnt_o, 0);
    do_cfg(16'hF, 5'd4, 0, 8'd1, 16'd4);
    step();
    check("win_sticky", timeout_o, 1);
    do_start();
    for (int i = 0; i < 4; i++) bit_in(1);
    step();
    check("tie_done",    done_o, 1);
    check("tie_det",     det_o, 1);
    check("tie_timeout", timeout_o, 0);

    // Illegal configs, rejected start, gapped stream.
    do_cfg(16'hF, 5'd0, 0, 8'd1, 16'd0);
    step();
    check("ill0_err",   cfg_err_o, 1);
    check("ill0_ready", cfg_ready_o, 1);
    do_start();
    step();
    check("ill_start_busy", busy_o, 0);
    check("ill_start_err",  cfg_err_o, 1);
    do_cfg(16'hF, 5'd17, 0, 8'd1, 16'd0);
    step();
    check("ill17_err", cfg_err_o, 1);
    pat = 16'h0EDB;
    do_cfg(pat, 5'd12, 0, 8'd1, 16'd0);
    step();
    check("legal_clears_err", cfg_err_o, 0);
    do_start();
    for (int i = 11; i >= 0; i--) begin
      bit_in(pat[i]);
      if (i % 3 == 1) begin step(); step(); end
    end
    step();
    check("gap_det",  det_o, 1);
    check("gap_done", done_o, 1);

    // Abort on the matching final bit.
    do_cfg(16'h5, 5'd3, 0, 8'd1, 16'd0);
    do_start();
    bit_in(1); bit_in(0);
    step();
    x_valid_i = 1; x_i = 1; abort_i = 1;
    step();
    check("abort_det",   det_o, 0);
    check("abort_done",  done_o, 0);
    check("abort_ready", cfg_ready_o, 1);
    check("abort_hit",   hit_cnt_o, 0);

    // Reset mid-run, then start must be rejected.
    do_start();
    bit_in(1); bit_in(0);
    step();
    reset = 0;
    step();
    check("mrst_ready", cfg_ready_o, 1);
    check("mrst_busy",  busy_o, 0);
    check("mrst_done",  done_o, 0);
    check("mrst_err",   cfg_err_o, 0);
    reset = 1;
    do_start();
    step();
    check("mrst_start_busy", busy_o, 0);
    check("mrst_start_err",  cfg_err_o, 1);

    // Random traffic; the scoreboard checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      step();
      reset         = ($urandom_range(0, 299) != 0);
      cfg_valid_i   = ($urandom_range(0, 9) == 0);
      cfg_pattern_i = MAX_LEN'($urandom);
      r = $urandom_range(0, 19);
      if (r < 12)      cfg_len_i = LEN_W'($urandom_range(1, 4));
      else if (r < 17) cfg_len_i = LEN_W'($urandom_range(5, 16));
      else if (r < 18) cfg_len_i = '0;
      else             cfg_len_i = LEN_W'($urandom_range(17, 31));
      cfg_overlap_i = 1'($urandom_range(0, 1));
      cfg_target_i  = CNT_W'($urandom_range(0, 4));
      cfg_window_i  = ($urandom_range(0, 2) == 0) ? '0 : WIN_W'($urandom_range(1, 30));
      start_i       = ($urandom_range(0, 5) == 0);
      abort_i       = ($urandom_range(0, 39) == 0);
      x_valid_i     = ($urandom_range(0, 3) != 0);
      x_i           = 1'($urandom_range(0, 1));
    end
    step();
    reset = 1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run-control wrapper around a programmable serial shift-and-compare detector (up to MAX_LEN bits). It accepts a pattern configuration through a valid/ready handshake and arms on start_i. While armed it accepts qualified serial bits, counts hits (overlapping or non-overlapping) and finishes on a hit-count target or an observation window. It sits between the software/config side and the serial bit stream and reports det/done/timeout status.

Parameters:
MAX_LEN, 16, maximum pattern length in bits
CNT_W, 8, width of the hit counter and target
WIN_W, 16, width of the window (bit budget) counter
LEN_W, $clog2(MAX_LEN)+1, width of the length field (derived; do not override)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
cfg_valid_i  in  1  config request
cfg_ready_o  out  1  config accepted; high iff state==IDLE
cfg_pattern_i  in  MAX_LEN  pattern; bit[len-1] is the first bit received, bit[0] the last
cfg_len_i  in  LEN_W  pattern length; legal range 1..MAX_LEN
cfg_overlap_i  in  1  1 = overlapping matches allowed
cfg_target_i  in  CNT_W  hits to finish; 0 = unlimited
cfg_window_i  in  WIN_W  accepted-bit budget; 0 = unlimited
start_i  in  1  arm request
abort_i  in  1  cancel an armed run
x_valid_i  in  1  serial bit qualifier
x_i  in  1  serial data bit
det_o  out  1  one-cycle match pulse
hit_cnt_o  out  CNT_W  hits in current/last run; saturates at all-ones
busy_o  out  1  state==ARMED
done_o  out  1  one-cycle run-complete pulse
timeout_o  out  1  last run ended on window expiry; sticky until next start
cfg_err_o  out  1  sticky error; cleared by the next legal config

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Reset (reset==0 at a clk edge) does the following:
  - state=IDLE, config invalid (cfg_ok=0)
  - shift register, fill counter, bit counter and hit_cnt_o cleared to 0
  - det_o, done_o, timeout_o, cfg_err_o, busy_o = 0; cfg_ready_o = 1
  - Reset asserted mid-run aborts the run and produces no done_o.
- FSM states: IDLE, ARMED, DONE.
- IDLE, config handshake:
  - cfg_valid_i & cfg_ready_o transfers the config.
  - cfg_len_i of 0 or >MAX_LEN: config is not latched, cfg_ok=0, cfg_err_o=1.
  - Legal length: all fields are latched, cfg_ok=1, cfg_err_o=0.
- IDLE, start:
  - start_i with cfg_ok=1 -> ARMED. Shift register, fill, bit counter, hit_cnt_o and timeout_o are cleared.
  - start_i with cfg_ok=0 is ignored and sets cfg_err_o=1.
  - If cfg_valid_i and start_i arrive in the same cycle, config is taken and start is ignored.
- ARMED, bit acceptance: a bit is accepted when x_valid_i=1. On each accepted bit:
  - next_shift = {shift[MAX_LEN-2:0], x_i}
  - fill increments, saturating at MAX_LEN
  - bit_cnt increments
- Match condition: fill+1 >= len, and next_shift masked to the low len bits equals the pattern masked to the low len bits.
- On a match:
  - det_o=1 in the cycle after the accepting edge (latency 1, registered).
  - hit_cnt_o increments, saturating.
  - If cfg_overlap=0, fill and shift are cleared at the same edge, so the next match needs len fresh bits.
- Run termination:
  - Target reached (target!=0 and new hit count == target): -> DONE, timeout_o=0.
  - Window expired (window!=0 and new bit_cnt == window, target not reached): -> DONE, timeout_o=1.
  - If both happen on the same bit, the target wins and timeout_o=0.
- Abort: abort_i in ARMED -> IDLE with no done_o. hit_cnt_o is held. abort_i has priority over a bit accepted in the same cycle; that bit is dropped (no det_o).
- Ignored requests: start_i in ARMED/DONE, abort_i outside ARMED, and cfg_valid_i outside IDLE (cfg_ready_o=0) are all ignored.
- DONE: lasts exactly one cycle with done_o=1 (coincides with the final det_o when the target ended the run), then -> IDLE. Config is retained, so start_i re-runs without reconfiguring.
- det_o is never asserted outside the cycle following an accepted bit.

Decomposition:
- Package seq_det_pkg holds:
  - state_t enum {IDLE, ARMED, DONE}
  - default MAX_LEN/CNT_W/WIN_W localparams
  - a cfg_t packed struct {pattern, len, overlap, target, window}
- Sub-module seq_shift_match holds the datapath: shift register, length mask, fill counter and compare. Its interface is:
  - inputs: shift enable, clear, x_i, pattern, len
  - output: combinational match_next
- seq_det_ctrl owns the FSM, bit/hit counters and all status outputs.

Test Plan:
- Basic run. Config pattern 12'hEDB, len 12, overlap 0, target 1, window 0; start; feed 1110_1101_1011 MSB first with x_valid_i=1. Expect det_o=1 and done_o=1 in the cycle after the 12th bit, hit_cnt_o=1, then IDLE with cfg_ready_o=1.
- Overlap on. Pattern 3'b101, len 3, target 0; stream 1,0,1,0,1. Expect det_o after bits 3 and 5, hit_cnt_o=2.
- Overlap off. Same pattern and stream with overlap 0. Expect a single det_o after bit 3, hit_cnt_o=1; busy_o stays 1.
- Window and tie. Pattern 4'b1111, window 8; feed 8 zeros. Expect done_o and timeout_o after the 8th bit, hit_cnt_o=0. Then with pattern 4'b1111, window 4, target 1, feed 1111: expect done_o with timeout_o=0 (target wins).
- Illegal config and qualifier gaps. cfg_len_i=0 -> cfg_err_o=1, cfg_ready_o stays 1, start_i ignored (busy_o=0). A legal config then clears cfg_err_o. Idle x_valid_i=0 cycles inserted inside the pattern do not affect matching or latency.
- Abort and reset. abort_i together with a matching final bit -> no det_o, no done_o, IDLE. reset=0 mid-ARMED -> all outputs 0 and cfg_ready_o=1 on the next cycle; start_i is then rejected with cfg_err_o=1.
